datapath_seq: RTL and testbench

- Hardwired control sequencer for the 32-bit bus DataPath.
- Replaces hand-driven bench timing: generates fetch (T0-T2) and execute (T3-T6) control strobes for register-register ALU instructions.
- Decodes the IR fields and sequences one instruction per pass; loops while run is held.
- Handles a memory-ready handshake with timeout, illegal opcodes and halt.

---
 rtl/datapath_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// datapath_seq : hardwired fetch/execute control sequencer for the bus DataPath
// Rev 1.0
// ---------------------------------------------------------------------------
module datapath_seq #(
    parameter int WAIT_MAX = 8
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin_low,
    output logic        Zin_high,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [3:0]  operation,
    output logic        done,
    output logic        illegal,
    output logic        bus_error,
    output logic        halted,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_ILL  = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    localparam logic [7:0] C_WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam logic [4:0] C_OP_HALT   = 5'b11011;

    state_t     cur;
    logic [7:0] wait_cnt;
    logic [4:0] opc;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       ill_q;
    logic       berr_q;

    logic       is_bin;
    logic       is_un;
    logic       is_md;
    logic [3:0] alu_op;

    // Only the decoded fields of the IR are consumed here.
    wire ir_unused = ^ir[14:0];

    always_comb begin
        is_bin = 1'b0;
        is_un  = 1'b0;
        alu_op = 4'd0;
        case (opc)
            5'b00011: begin is_bin = 1'b1; alu_op = 4'd0;  end
            5'b00100: begin is_bin = 1'b1; alu_op = 4'd1;  end
            5'b00101: begin is_bin = 1'b1; alu_op = 4'd2;  end
            5'b00110: begin is_bin = 1'b1; alu_op = 4'd3;  end
            5'b01001: begin is_bin = 1'b1; alu_op = 4'd4;  end
            5'b00111: begin is_bin = 1'b1; alu_op = 4'd5;  end
            5'b01010: begin is_bin = 1'b1; alu_op = 4'd6;  end
            5'b01011: begin is_bin = 1'b1; alu_op = 4'd7;  end
            5'b01111: begin is_bin = 1'b1; alu_op = 4'd8;  end
            5'b10000: begin is_bin = 1'b1; alu_op = 4'd9;  end
            5'b10001: begin is_un  = 1'b1; alu_op = 4'd10; end
            5'b10010: begin is_un  = 1'b1; alu_op = 4'd11; end
            default:  ;
        endcase
    end

    assign is_md = (opc == 5'b01111) || (opc == 5'b10000);

    always_ff @(posedge Clock) begin
        if (clear) begin
            cur      <= ST_IDLE;
            wait_cnt <= 8'd0;
            opc      <= 5'd0;
            ra       <= 4'd0;
            rb       <= 4'd0;
            rc       <= 4'd0;
            ill_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            case (cur)
                ST_IDLE: if (run) cur <= ST_T0;
                ST_T0:   cur <= ST_T1;
                ST_T1: begin
                    if (mem_ready) begin
                        wait_cnt <= 8'd0;
                        cur      <= ST_T2;
                    end else if (wait_cnt == C_WAIT_LAST) begin
                        wait_cnt <= 8'd0;
                        berr_q   <= 1'b1;
                        cur      <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_T2: begin
                    // Fields are captured as T3 is entered and held through T6.
                    opc <= ir[31:27];
                    ra  <= ir[26:23];
                    rb  <= ir[22:19];
                    rc  <= ir[18:15];
                    cur <= ST_T3;
                end
                ST_T3: begin
                    if (opc == C_OP_HALT) begin
                        cur <= ST_HALT;
                    end else if (!(is_bin || is_un)) begin
                        ill_q <= 1'b1;
                        cur   <= ST_ILL;
                    end else begin
                        cur <= ST_T4;
                    end
                end
                ST_T4: cur <= ST_T5;
                ST_T5: begin
                    if (is_md)    cur <= ST_T6;
                    else if (run) cur <= ST_T0;
                    else          cur <= ST_IDLE;
                end
                ST_T6, ST_ILL: cur <= run ? ST_T0 : ST_IDLE;
                ST_HALT: cur <= ST_HALT;
                default: cur <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout     = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin_low   = 1'b0;
        Zin_high  = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Rout      = 16'd0;
        Rin       = 16'd0;
        operation = 4'd0;
        done      = 1'b0;
        case (cur)
            ST_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin_low = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = (wait_cnt == 8'd0);
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                operation = alu_op;
                if (is_bin) begin
                    Rout = 16'd1 << rb;
                    Yin  = 1'b1;
                end
            end
            ST_T4: begin
                operation = alu_op;
                Zin_low   = 1'b1;
                Zin_high  = is_md;
                Rout      = is_bin ? (16'd1 << rc) : (16'd1 << rb);
            end
            ST_T5: begin
                operation = alu_op;
                Zlowout   = 1'b1;
                if (is_md) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = 16'd1 << ra;
                    done = 1'b1;
                end
            end
            ST_T6: begin
                operation = alu_op;
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                done      = 1'b1;
            end
            ST_ILL:  done = 1'b1;
            default: ;
        endcase
    end

    assign halted    = (cur == ST_HALT);
    assign illegal   = ill_q;
    assign bus_error = berr_q;
    assign state     = cur;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// tb_datapath_seq : cycle-level scoreboard bench for the datapath_seq sequencer.
module tb_datapath_seq;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = 32'd0;

    wire [14:0] str;
    wire [15:0] Rout, Rin;
    wire [3:0]  operation, state;
    wire        done, illegal, bus_error, halted;

    wire [14:0] b_str;
    wire [15:0] b_Rout, b_Rin;
    wire [3:0]  b_operation, b_state;
    wire        b_done, b_illegal, b_bus_error, b_halted;

    always #5 Clock = ~Clock;

    datapath_seq #(.WAIT_MAX(8)) dut (
        .Clock(Clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(str[14]), .IncPC(str[13]), .MARin(str[12]), .PCin(str[11]),
        .Read(str[10]), .MDRin(str[9]), .MDRout(str[8]), .IRin(str[7]),
        .Yin(str[6]), .Zin_low(str[5]), .Zin_high(str[4]), .Zlowout(str[3]),
        .Zhighout(str[2]), .HIin(str[1]), .LOin(str[0]),
        .Rout(Rout), .Rin(Rin), .operation(operation), .done(done),
        .illegal(illegal), .bus_error(bus_error), .halted(halted), .state(state)
    );

    datapath_seq #(.WAIT_MAX(4)) dut4 (
        .Clock(Clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(b_str[14]), .IncPC(b_str[13]), .MARin(b_str[12]), .PCin(b_str[11]),
        .Read(b_str[10]), .MDRin(b_str[9]), .MDRout(b_str[8]), .IRin(b_str[7]),
        .Yin(b_str[6]), .Zin_low(b_str[5]), .Zin_high(b_str[4]), .Zlowout(b_str[3]),
        .Zhighout(b_str[2]), .HIin(b_str[1]), .LOin(b_str[0]),
        .Rout(b_Rout), .Rin(b_Rin), .operation(b_operation), .done(b_done),
        .illegal(b_illegal), .bus_error(b_bus_error), .halted(b_halted), .state(b_state)
    );

    localparam logic [14:0] PCOUT  = 15'h4000, INCPC = 15'h2000, MARIN = 15'h1000;
    localparam logic [14:0] PCIN   = 15'h0800, READ  = 15'h0400, MDRIN = 15'h0200;
    localparam logic [14:0] MDROUT = 15'h0100, IRIN  = 15'h0080, YIN   = 15'h0040;
    localparam logic [14:0] ZINL   = 15'h0020, ZINH  = 15'h0010, ZLO   = 15'h0008;
    localparam logic [14:0] ZHO    = 15'h0004, HIIN  = 15'h0002, LOIN  = 15'h0001;
    localparam logic [14:0] NONE   = 15'h0000;

    localparam logic [3:0] I_IDLE = 4'd0, I_T0 = 4'd1, I_T1 = 4'd2, I_T2 = 4'd3;
    localparam logic [3:0] I_T3 = 4'd4, I_T4 = 4'd5, I_T5 = 4'd6, I_T6 = 4'd7;
    localparam logic [3:0] I_ILL = 4'd8, I_HALT = 4'd9;

    // One record per clock: expected outputs plus the inputs to apply in that cycle.
    typedef struct {
        logic [3:0]  st;
        logic [14:0] sb;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [3:0]  op;
        logic        dn;
        logic        run;
        logic        mr;
        logic        clr;
        logic [31:0] ir;
    } rec_t;

    rec_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic push(input logic [3:0] st, input logic [14:0] sb,
                        input logic [15:0] ro, input logic [15:0] ri,
                        input logic [3:0] op, input logic dn,
                        input logic r, input logic m, input logic c,
                        input logic [31:0] i);
        rec_t e;
        e.st = st; e.sb = sb; e.rout = ro; e.rin = ri; e.op = op; e.dn = dn;
        e.run = r; e.mr = m; e.clr = c; e.ir = i;
        q.push_back(e);
    endtask

    task automatic model_instr(input logic [31:0] i, input int waits,
                               input logic run_tail, input logic abort_t4);
        logic [4:0] o;
        logic [3:0] a, b, c, op;
        logic bin, un, md;
        o = i[31:27]; a = i[26:23]; b = i[22:19]; c = i[18:15];
        bin = 1'b1; un = 1'b0; md = 1'b0; op = 4'd0;
        case (o)
            5'd3:  op = 4'd0;
            5'd4:  op = 4'd1;
            5'd5:  op = 4'd2;
            5'd6:  op = 4'd3;
            5'd9:  op = 4'd4;
            5'd7:  op = 4'd5;
            5'd10: op = 4'd6;
            5'd11: op = 4'd7;
            5'd15: begin op = 4'd8; md = 1'b1; end
            5'd16: begin op = 4'd9; md = 1'b1; end
            5'd17: begin op = 4'd10; bin = 1'b0; un = 1'b1; end
            5'd18: begin op = 4'd11; bin = 1'b0; un = 1'b1; end
            default: bin = 1'b0;
        endcase
        push(I_T0, PCOUT | INCPC | MARIN | ZINL, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, i);
        for (int w = 0; w <= waits; w++)
            push(I_T1, ZLO | READ | MDRIN | ((w == 0) ? PCIN : NONE), 16'd0, 16'd0, 4'd0, 1'b0,
                 1'b1, (w == waits), 1'b0, i);
        push(I_T2, MDROUT | IRIN, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, i);
        if (!bin && !un) begin
            push(I_T3, NONE, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, i);
            if (o == 5'b11011)
                push(I_HALT, NONE, 16'd0, 16'd0, 4'd0, 1'b0, run_tail, 1'b1, 1'b0, i);
            else
                push(I_ILL, NONE, 16'd0, 16'd0, 4'd0, 1'b1, run_tail, 1'b1, 1'b0, i);
        end else begin
            push(I_T3, bin ? YIN : NONE, bin ? (16'd1 << b) : 16'd0, 16'd0, op, 1'b0,
                 1'b1, 1'b1, 1'b0, i);
            push(I_T4, ZINL | (md ? ZINH : NONE), bin ? (16'd1 << c) : (16'd1 << b), 16'd0,
                 op, 1'b0, run_tail, 1'b1, abort_t4, i);
            if (!abort_t4) begin
                push(I_T5, ZLO | (md ? LOIN : NONE), 16'd0, md ? 16'd0 : (16'd1 << a), op, !md,
                     run_tail, 1'b1, 1'b0, i);
                if (md)
                    push(I_T6, ZHO | HIIN, 16'd0, 16'd0, op, 1'b1, run_tail, 1'b1, 1'b0, i);
            end
        end
    endtask

    task automatic push_idle(input logic r);
        push(I_IDLE, NONE, 16'd0, 16'd0, 4'd0, 1'b0, r, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic drain(input string name);
        rec_t e;
        int n;
        n = 0;
        while (q.size() > 0) begin
            @(negedge Clock);
            e = q.pop_front();
            tests++;
            if ({state, str, Rout, Rin, operation, done, halted} !==
                {e.st, e.sb, e.rout, e.rin, e.op, e.dn, (e.st == I_HALT)}) begin
                fails++;
                $display("FAIL %s cyc%0d: got st=%0d str=%h rout=%h rin=%h op=%h done=%b halt=%b; want st=%0d str=%h rout=%h rin=%h op=%h done=%b",
                         name, n, state, str, Rout, Rin, operation, done, halted,
                         e.st, e.sb, e.rout, e.rin, e.op, e.dn);
            end
            run = e.run; mem_ready = e.mr; clear = e.clr; ir = e.ir;
            n++;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = 32'd0;
        repeat (2) @(negedge Clock);
        tests++;
        if ({state, str, Rout, Rin, operation, done, illegal, bus_error, halted, b_state} !== 62'd0) begin
            fails++;
            $display("FAIL reset: got st=%0d str=%h rout=%h rin=%h op=%h done=%b ill=%b berr=%b halt=%b; want all 0",
                     state, str, Rout, Rin, operation, done, illegal, bus_error, halted);
        end
        clear = 1'b0; run = 1'b0;
    endtask

    task automatic test_add();
        run = 1'b1; mem_ready = 1'b1; ir = 32'h18918000;
        model_instr(32'h18918000, 0, 1'b0, 1'b0);
        push_idle(1'b0);
        drain("add");
    endtask

    task automatic test_mul();
        run = 1'b1; ir = 32'h78338000;
        model_instr(32'h78338000, 0, 1'b0, 1'b0);
        push_idle(1'b0);
        drain("mul");
    endtask

    task automatic test_mem_wait();
        run = 1'b1; ir = 32'h18918000;
        model_instr(32'h18918000, 3, 1'b0, 1'b0);
        push_idle(1'b0);
        drain("mem_wait");
    endtask

    task automatic test_bus_error();
        int n;
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0; run = 1'b1; mem_ready = 1'b0; ir = 32'h18918000;
        n = 0;
        for (int k = 0; k < 20 && b_state != I_HALT; k++) begin
            @(negedge Clock);
            if (b_state == I_T1) n++;
        end
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL berr_t1_cycles: got %0d want 4", n);
        end
        tests++;
        if ({b_bus_error, b_halted, b_state} !== {1'b1, 1'b1, I_HALT}) begin
            fails++;
            $display("FAIL berr_halt: got berr=%b halt=%b st=%0d want 1 1 9", b_bus_error, b_halted, b_state);
        end
        tests++;
        if ({bus_error, state} !== {1'b0, I_T1}) begin
            fails++;
            $display("FAIL berr_wait8: got berr=%b st=%0d want 0 2", bus_error, state);
        end
        @(negedge Clock);
        tests++;
        if (b_state !== I_HALT) begin
            fails++;
            $display("FAIL berr_stay: got st=%0d want 9", b_state);
        end
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1;
        @(negedge Clock);
        clear = 1'b0;
        tests++;
        if ({b_bus_error, b_state, state} !== 9'd0) begin
            fails++;
            $display("FAIL berr_clear: got berr=%b st4=%0d st=%0d want 0 0 0", b_bus_error, b_state, state);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ill_ir, sub_ir;
        ill_ir = {5'b11111, 4'd5, 4'd6, 4'd7, 15'd0};
        sub_ir = {5'b00100, 4'd15, 4'd0, 4'd9, 15'd0};
        run = 1'b1; ir = ill_ir;
        model_instr(ill_ir, 0, 1'b1, 1'b0);
        model_instr(sub_ir, 0, 1'b0, 1'b0);
        push_idle(1'b0);
        drain("illegal");
        tests++;
        if ({illegal, bus_error} !== 2'b10) begin
            fails++;
            $display("FAIL illegal_flag: got ill=%b berr=%b want 1 0", illegal, bus_error);
        end
    endtask

    task automatic test_clear_mid();
        run = 1'b1; ir = 32'h18918000;
        model_instr(32'h18918000, 0, 1'b1, 1'b1);
        push_idle(1'b1);
        model_instr(32'h18918000, 0, 1'b0, 1'b0);
        push_idle(1'b0);
        drain("clear_mid");
        tests++;
        if (illegal !== 1'b0) begin
            fails++;
            $display("FAIL clear_sticky: got ill=%b want 0", illegal);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [12];
        logic [31:0] i;
        ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01001, 5'b00111,
                5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};
        run = 1'b1;
        for (int k = 0; k < 12; k++) begin
            i = {ops[k], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 15'($urandom)};
            if (k == 0) ir = i;
            model_instr(i, k % 3, (k != 11), 1'b0);
        end
        push_idle(1'b0);
        drain("back_to_back");
    endtask

    task automatic test_halt();
        logic [31:0] h;
        h = {5'b11011, 27'd0};
        run = 1'b1; ir = h;
        model_instr(h, 0, 1'b1, 1'b0);
        repeat (3) push(I_HALT, NONE, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, h);
        drain("halt");
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0; run = 1'b0;
        tests++;
        if ({state, halted} !== {I_IDLE, 1'b0}) begin
            fails++;
            $display("FAIL halt_clear: got st=%0d halt=%b want 0 0", state, halted);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_mem_wait();
        test_bus_error();
        test_illegal();
        test_clear_mid();
        test_back_to_back();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
